// File: rtl/acia_loader.sv
// acia_loader: serial boot loader that masters the ACIA register bus while
// the 65C02 is held off. It configures the ACIA, hunts for the 0x55 sync byte,
// collects a 16-bit address and length, streams the payload into RAM, checks
// the 8-bit additive checksum and answers ACK (0x06) or NAK (0x15).
module acia_loader #(
  parameter logic [3:0]  BAUD_SEL    = 4'b0000,
  parameter logic [7:0]  CMD_VAL     = 8'h0A,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  acia_rs,
  output logic        acia_we,
  output logic        acia_en,
  output logic [7:0]  acia_din,
  input  logic [7:0]  acia_dout,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_CMD,
    S_CFG_CTRL,
    S_POLL_RX,
    S_READ_RX,
    S_WRITE_MEM,
    S_POLL_TX,
    S_WRITE_TX
  } state_t;

  // Which frame field the next received byte belongs to.
  typedef enum logic [2:0] {
    F_SYNC,
    F_AHI,
    F_ALO,
    F_LHI,
    F_LLO,
    F_DATA,
    F_CHK
  } field_t;

  localparam logic [7:0]  SYNC_BYTE = 8'h55;
  localparam logic [7:0]  ACK_BYTE  = 8'h06;
  localparam logic [7:0]  NAK_BYTE  = 8'h15;
  localparam logic [1:0]  RS_DATA   = 2'b00;
  localparam logic [1:0]  RS_STAT   = 2'b01;
  localparam logic [1:0]  RS_CMD    = 2'b10;
  localparam logic [1:0]  RS_CTRL   = 2'b11;
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_n;
  field_t      field;
  logic [15:0] addr;
  logic [15:0] len;
  logic [7:0]  sum;
  logic [7:0]  reply;
  logic [31:0] to_cnt;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        tx_ready;
  logic        timeout_hit;

  assign rx_byte  = acia_dout;
  assign rx_ready = acia_dout[3];
  assign tx_ready = acia_dout[4];

  // The inter-byte timer only matters once a sync byte has opened a frame;
  // a byte arriving in the same poll cycle wins over the timeout.
  assign timeout_hit = (state == S_POLL_RX) && (field != F_SYNC) &&
                       !rx_ready && (to_cnt >= TO_LAST);

  assign busy     = (state != S_IDLE);
  assign cpu_hold = busy;
  assign mem_addr = addr;

  // State register; reset drops the bus immediately without sending a reply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state selection from the current state and ACIA status/data.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (start) state_n = S_CFG_CMD;
      S_CFG_CMD:   state_n = S_CFG_CTRL;
      S_CFG_CTRL:  state_n = S_POLL_RX;
      S_POLL_RX: begin
        if (rx_ready)         state_n = S_READ_RX;
        else if (timeout_hit) state_n = S_POLL_TX;
      end
      S_READ_RX: begin
        case (field)
          F_DATA:  state_n = S_WRITE_MEM;
          F_CHK:   state_n = S_POLL_TX;
          default: state_n = S_POLL_RX;
        endcase
      end
      S_WRITE_MEM: state_n = S_POLL_RX;
      S_POLL_TX:   if (tx_ready) state_n = S_WRITE_TX;
      S_WRITE_TX:  state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Bus strobes decoded from the state alone: one ACIA access per busy cycle
  // except the RAM write cycle, which leaves the ACIA idle.
  always_comb begin
    acia_en  = 1'b0;
    acia_we  = 1'b0;
    acia_rs  = RS_DATA;
    acia_din = 8'h00;
    mem_we   = 1'b0;
    case (state)
      S_CFG_CMD: begin
        acia_en  = 1'b1;
        acia_we  = 1'b1;
        acia_rs  = RS_CMD;
        acia_din = CMD_VAL;
      end
      S_CFG_CTRL: begin
        acia_en  = 1'b1;
        acia_we  = 1'b1;
        acia_rs  = RS_CTRL;
        acia_din = {4'h0, BAUD_SEL};
      end
      S_POLL_RX, S_POLL_TX: begin
        acia_en = 1'b1;
        acia_rs = RS_STAT;
      end
      S_READ_RX: begin
        acia_en = 1'b1;
        acia_rs = RS_DATA;
      end
      S_WRITE_MEM: mem_we = 1'b1;
      S_WRITE_TX: begin
        acia_en  = 1'b1;
        acia_we  = 1'b1;
        acia_rs  = RS_DATA;
        acia_din = reply;
      end
      default: ;
    endcase
  end

  // Frame parser datapath: field tracking, address/length, checksum,
  // timeout counter and the sticky done/error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      field    <= F_SYNC;
      addr     <= 16'h0000;
      len      <= 16'h0000;
      sum      <= 8'h00;
      reply    <= 8'h00;
      to_cnt   <= 32'd0;
      done     <= 1'b0;
      error    <= 1'b0;
      mem_data <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done   <= 1'b0;
            error  <= 1'b0;
            to_cnt <= 32'd0;
            field  <= F_SYNC;
          end
        end
        S_CFG_CTRL: begin
          field  <= F_SYNC;
          to_cnt <= 32'd0;
        end
        S_POLL_RX: begin
          if (!rx_ready && (field != F_SYNC)) begin
            if (timeout_hit) begin
              error <= 1'b1;
              reply <= NAK_BYTE;
            end else begin
              to_cnt <= to_cnt + 32'd1;
            end
          end
        end
        S_READ_RX: begin
          to_cnt <= 32'd0;
          case (field)
            F_SYNC: if (rx_byte == SYNC_BYTE) field <= F_AHI;
            F_AHI: begin
              addr[15:8] <= rx_byte;
              field      <= F_ALO;
            end
            F_ALO: begin
              addr[7:0] <= rx_byte;
              field     <= F_LHI;
            end
            F_LHI: begin
              len[15:8] <= rx_byte;
              field     <= F_LLO;
            end
            F_LLO: begin
              len[7:0] <= rx_byte;
              sum      <= 8'h00;
              field    <= ({len[15:8], rx_byte} == 16'h0000) ? F_CHK : F_DATA;
            end
            F_DATA: begin
              mem_data <= rx_byte;
              sum      <= sum + rx_byte;
            end
            F_CHK: begin
              reply <= (rx_byte == sum) ? ACK_BYTE : NAK_BYTE;
              if (rx_byte != sum) error <= 1'b1;
            end
            default: field <= F_SYNC;
          endcase
        end
        S_WRITE_MEM: begin
          addr <= addr + 16'd1;
          len  <= len - 16'd1;
          if (len == 16'd1) field <= F_CHK;
        end
        S_WRITE_TX: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
